coin_payment: RTL and testbench

COIN_PAYMENT -- requirements
Module: coin_payment

---
 rtl/vm_pkg.sv | 16 +
 rtl/pay_timer.sv | 29 ++
 rtl/coin_payment.sv | 176 +++++++++++++++++
 tb/tb_coin_payment.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared types and constants for the coin payment controller.
package vm_pkg;

   localparam int MONEY_W     = 8;
   localparam int COIN_V0_DEF = 1;
   localparam int COIN_V1_DEF = 5;
   localparam int COIN_V2_DEF = 10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PAY      = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_REFUND   = 2'd3
   } state_t;

endpackage

// File: rtl/pay_timer.sv
// Clearable saturating cycle counter; o_done holds once LIMIT-1 is reached.
module pay_timer #(
   parameter int LIMIT = 1000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_done
);

   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/coin_payment.sv
// Coin payment controller: latches a selection, accumulates coins, then
// dispenses with change or refunds on cancel/timeout. All outputs registered.
module coin_payment
   import vm_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int COIN_V0        = COIN_V0_DEF,
   parameter int COIN_V1        = COIN_V1_DEF,
   parameter int COIN_V2        = COIN_V2_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [MONEY_W-1:0] goods_price,
   input  logic [3:0]         goods_num,
   input  logic [2:0]         coin,
   input  logic               cancel,
   output logic [MONEY_W-1:0] paid_total,
   output logic               busy,
   output logic               coin_reject,
   output logic               dispense,
   output logic [3:0]         dispense_num,
   output logic [MONEY_W-1:0] change,
   output logic               change_valid,
   output logic               refund,
   output logic [1:0]         o_dbg_state
);

   state_t             r_state;
   logic [MONEY_W-1:0] r_paid;
   logic [MONEY_W-1:0] r_price;
   logic [3:0]         r_num;
   logic               r_busy;
   logic               r_reject;
   logic               r_dispense;
   logic [3:0]         r_disp_num;
   logic [MONEY_W-1:0] r_change;
   logic               r_change_valid;
   logic               r_refund;

   state_t             w_state_nxt;
   logic [MONEY_W-1:0] w_paid_nxt;
   logic [MONEY_W-1:0] w_price_nxt;
   logic [3:0]         w_num_nxt;
   logic               w_reject_nxt;
   logic               w_dispense_nxt;
   logic [3:0]         w_disp_num_nxt;
   logic [MONEY_W-1:0] w_change_nxt;
   logic               w_change_valid_nxt;
   logic               w_refund_nxt;

   logic [MONEY_W-1:0] w_coin_val;
   logic               w_onehot;
   logic [MONEY_W:0]   w_sum;
   logic               w_coin_accept;
   logic               w_timer_clr;
   logic               w_timer_done;

   always_comb begin
      w_coin_val = '0;
      w_onehot   = 1'b1;
      case (coin)
         3'b001:  w_coin_val = MONEY_W'(COIN_V0);
         3'b010:  w_coin_val = MONEY_W'(COIN_V1);
         3'b100:  w_coin_val = MONEY_W'(COIN_V2);
         default: w_onehot   = 1'b0;
      endcase
   end

   // Extra carry bit detects credits that would overflow the money width.
   assign w_sum         = {1'b0, r_paid} + {1'b0, w_coin_val};
   assign w_coin_accept = (r_state == ST_PAY) && !cancel && w_onehot && !w_sum[MONEY_W];
   assign w_timer_clr   = (r_state != ST_PAY) || w_coin_accept;

   pay_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_pay_timer (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_en    (r_state == ST_PAY),
      .i_clr   (w_timer_clr),
      .o_done  (w_timer_done)
   );

   always_comb begin
      w_state_nxt        = r_state;
      w_paid_nxt         = r_paid;
      w_price_nxt        = r_price;
      w_num_nxt          = r_num;
      w_reject_nxt       = (coin != 3'b000) && !w_coin_accept;
      w_dispense_nxt     = 1'b0;
      w_disp_num_nxt     = '0;
      w_change_nxt       = '0;
      w_change_valid_nxt = 1'b0;
      w_refund_nxt       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if ((goods_num != 4'd0) && (goods_price != '0)) begin
               w_price_nxt = goods_price;
               w_num_nxt   = goods_num;
               w_state_nxt = ST_PAY;
            end
         end
         ST_PAY: begin
            if (cancel) begin
               w_state_nxt        = ST_REFUND;
               w_refund_nxt       = 1'b1;
               w_change_nxt       = r_paid;
               w_change_valid_nxt = 1'b1;
            end else if (w_coin_accept) begin
               w_paid_nxt = w_sum[MONEY_W-1:0];
               // Completion is judged on the freshly credited total.
               if (w_sum[MONEY_W-1:0] >= r_price) begin
                  w_state_nxt        = ST_DISPENSE;
                  w_dispense_nxt     = 1'b1;
                  w_disp_num_nxt     = r_num;
                  w_change_nxt       = w_sum[MONEY_W-1:0] - r_price;
                  w_change_valid_nxt = 1'b1;
               end
            end else if (w_timer_done) begin
               w_state_nxt        = ST_REFUND;
               w_refund_nxt       = 1'b1;
               w_change_nxt       = r_paid;
               w_change_valid_nxt = 1'b1;
            end
         end
         ST_DISPENSE, ST_REFUND: begin
            w_state_nxt = ST_IDLE;
            w_paid_nxt  = '0;
            w_price_nxt = '0;
            w_num_nxt   = '0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_paid         <= '0;
         r_price        <= '0;
         r_num          <= '0;
         r_busy         <= 1'b0;
         r_reject       <= 1'b0;
         r_dispense     <= 1'b0;
         r_disp_num     <= '0;
         r_change       <= '0;
         r_change_valid <= 1'b0;
         r_refund       <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_paid         <= w_paid_nxt;
         r_price        <= w_price_nxt;
         r_num          <= w_num_nxt;
         r_busy         <= (w_state_nxt != ST_IDLE);
         r_reject       <= w_reject_nxt;
         r_dispense     <= w_dispense_nxt;
         r_disp_num     <= w_disp_num_nxt;
         r_change       <= w_change_nxt;
         r_change_valid <= w_change_valid_nxt;
         r_refund       <= w_refund_nxt;
      end
   end

   assign paid_total   = r_paid;
   assign busy         = r_busy;
   assign coin_reject  = r_reject;
   assign dispense     = r_dispense;
   assign dispense_num = r_disp_num;
   assign change       = r_change;
   assign change_valid = r_change_valid;
   assign refund       = r_refund;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_coin_payment.sv
// Directed bench for coin_payment: selection, payment, change, refund,
// timeout, overflow rejection and asynchronous reset.
module tb_coin_payment;

   localparam int TO = 8;

   logic       clk;
   logic       rst;
   logic [7:0] goods_price;
   logic [3:0] goods_num;
   logic [2:0] coin;
   logic       cancel;
   logic [7:0] paid_total;
   logic       busy;
   logic       coin_reject;
   logic       dispense;
   logic [3:0] dispense_num;
   logic [7:0] change;
   logic       change_valid;
   logic       refund;
   logic [1:0] o_dbg_state;

   int checks   = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   coin_payment #(
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .goods_price  (goods_price),
      .goods_num    (goods_num),
      .coin         (coin),
      .cancel       (cancel),
      .paid_total   (paid_total),
      .busy         (busy),
      .coin_reject  (coin_reject),
      .dispense     (dispense),
      .dispense_num (dispense_num),
      .change       (change),
      .change_valid (change_valid),
      .refund       (refund),
      .o_dbg_state  (o_dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic chk_change(input string tag);
      logic [7:0] exp_c;
      exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk(tag, {24'd0, change}, {24'd0, exp_c});
   endtask

   task automatic select_item(input logic [7:0] p, input logic [3:0] n);
      goods_price = p;
      goods_num   = n;
      tick();
      goods_price = 8'd0;
      goods_num   = 4'd0;
   endtask

   task automatic put_coin(input logic [2:0] c);
      coin = c;
      tick();
      coin = 3'b000;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_paid"}, {24'd0, paid_total}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_reject"}, {31'd0, coin_reject}, 32'd0);
      chk({tag, "_dispense"}, {31'd0, dispense}, 32'd0);
      chk({tag, "_disp_num"}, {28'd0, dispense_num}, 32'd0);
      chk({tag, "_change"}, {24'd0, change}, 32'd0);
      chk({tag, "_cv"}, {31'd0, change_valid}, 32'd0);
      chk({tag, "_refund"}, {31'd0, refund}, 32'd0);
      chk({tag, "_state"}, {30'd0, o_dbg_state}, 32'd0);
   endtask

   initial begin
      int n_wait;
      rst         = 1'b0;
      goods_price = 8'd0;
      goods_num   = 4'd0;
      coin        = 3'b000;
      cancel      = 1'b0;
      tick();
      tick();
      chk_idle_outputs("reset");
      rst = 1'b1;
      tick();

      // price 15 code 2: 10 then 5, selection changes during PAY are ignored
      select_item(8'd15, 4'd2);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_state", {30'd0, o_dbg_state}, 32'd1);
      goods_price = 8'd1;
      goods_num   = 4'd7;
      put_coin(3'b100);
      goods_price = 8'd0;
      goods_num   = 4'd0;
      chk("t1_paid10", {24'd0, paid_total}, 32'd10);
      chk("t1_no_disp", {31'd0, dispense}, 32'd0);
      exp_q.push_back(8'd0);
      put_coin(3'b010);
      chk("t1_dispense", {31'd0, dispense}, 32'd1);
      chk("t1_num", {28'd0, dispense_num}, 32'd2);
      chk("t1_cv", {31'd0, change_valid}, 32'd1);
      chk_change("t1_change");
      chk("t1_paid15", {24'd0, paid_total}, 32'd15);
      chk("t1_norefund", {31'd0, refund}, 32'd0);
      tick();
      chk_idle_outputs("t1_after");

      // price 12: change 3, coin during DISPENSE rejected
      select_item(8'd12, 4'd3);
      put_coin(3'b100);
      exp_q.push_back(8'd3);
      put_coin(3'b010);
      chk("t2_dispense", {31'd0, dispense}, 32'd1);
      chk("t2_num", {28'd0, dispense_num}, 32'd3);
      chk_change("t2_change");
      put_coin(3'b010);
      chk("t2_reject", {31'd0, coin_reject}, 32'd1);
      chk("t2_paid0", {24'd0, paid_total}, 32'd0);
      chk("t2_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("t2_reject_clr", {31'd0, coin_reject}, 32'd0);

      // price 20: coin 10 then cancel with simultaneous coin 5
      select_item(8'd20, 4'd4);
      put_coin(3'b100);
      cancel = 1'b1;
      exp_q.push_back(8'd10);
      put_coin(3'b010);
      cancel = 1'b0;
      chk("t3_refund", {31'd0, refund}, 32'd1);
      chk_change("t3_change");
      chk("t3_cv", {31'd0, change_valid}, 32'd1);
      chk("t3_reject", {31'd0, coin_reject}, 32'd1);
      chk("t3_nodisp", {31'd0, dispense}, 32'd0);
      tick();
      chk("t3_paid0", {24'd0, paid_total}, 32'd0);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk("idle_cancel_refund", {31'd0, refund}, 32'd0);
      chk("idle_cancel_busy", {31'd0, busy}, 32'd0);
      put_coin(3'b100);
      chk("idle_coin_reject", {31'd0, coin_reject}, 32'd1);
      chk("idle_coin_paid", {24'd0, paid_total}, 32'd0);

      // timeout: price 30, coin 5, refund after TO quiet cycles
      select_item(8'd30, 4'd5);
      put_coin(3'b010);
      chk("t4_paid5", {24'd0, paid_total}, 32'd5);
      n_wait = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (refund) begin
            n_wait = i;
            break;
         end
      end
      chk("t4_timeout_cycles", n_wait, TO);
      exp_q.push_back(8'd5);
      chk_change("t4_change");
      chk("t4_cv", {31'd0, change_valid}, 32'd1);
      tick();

      // multi-bit coin rejected in PAY
      select_item(8'd30, 4'd5);
      put_coin(3'b011);
      chk("t4b_reject", {31'd0, coin_reject}, 32'd1);
      chk("t4b_paid0", {24'd0, paid_total}, 32'd0);
      put_coin(3'b001);
      chk("t4b_paid1", {24'd0, paid_total}, 32'd1);
      chk("t4b_noreject", {31'd0, coin_reject}, 32'd0);
      cancel = 1'b1;
      exp_q.push_back(8'd1);
      tick();
      cancel = 1'b0;
      chk("t4b_refund", {31'd0, refund}, 32'd1);
      chk_change("t4b_change");
      tick();

      // overflow: price 255, 250 paid, coin 10 rejected, coin 5 completes
      select_item(8'd255, 4'd6);
      for (int i = 0; i < 25; i++) put_coin(3'b100);
      chk("t5_paid250", {24'd0, paid_total}, 32'd250);
      put_coin(3'b100);
      chk("t5_ovf_reject", {31'd0, coin_reject}, 32'd1);
      chk("t5_ovf_paid", {24'd0, paid_total}, 32'd250);
      chk("t5_ovf_busy", {31'd0, busy}, 32'd1);
      exp_q.push_back(8'd0);
      put_coin(3'b010);
      chk("t5_dispense", {31'd0, dispense}, 32'd1);
      chk("t5_num", {28'd0, dispense_num}, 32'd6);
      chk_change("t5_change");
      chk("t5_paid255", {24'd0, paid_total}, 32'd255);
      tick();

      // asynchronous reset mid-PAY with 15 credited
      select_item(8'd20, 4'd7);
      put_coin(3'b100);
      put_coin(3'b010);
      chk("t6_paid15", {24'd0, paid_total}, 32'd15);
      #2;
      rst = 1'b0;
      #1;
      chk_idle_outputs("t6_async");
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_norefund", {31'd0, refund}, 32'd0);
         chk("t6_nobusy", {31'd0, busy}, 32'd0);
      end

      // recovery after reset
      select_item(8'd1, 4'd1);
      exp_q.push_back(8'd0);
      put_coin(3'b001);
      chk("t7_dispense", {31'd0, dispense}, 32'd1);
      chk("t7_num", {28'd0, dispense_num}, 32'd1);
      chk_change("t7_change");
      tick();
      chk("t7_queue_empty", exp_q.size(), 32'd0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
